// File: rtl/muldiv_sched_pkg.sv
// Shared types and constants for the M-extension multiply/divide scheduler.
package muldiv_sched_pkg;

   localparam int unsigned XLEN = 64;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_BUSY,
      ST_DONE
   } state_t;

   typedef enum logic [2:0] {
      OP_MUL    = 3'b000,
      OP_MULH   = 3'b001,
      OP_MULHSU = 3'b010,
      OP_MULHU  = 3'b011,
      OP_DIV    = 3'b100,
      OP_DIVU   = 3'b101,
      OP_REM    = 3'b110,
      OP_REMU   = 3'b111
   } op_t;

   // {src1 signed, src2 signed}
   localparam logic [1:0] SGN_UU = 2'b00;
   localparam logic [1:0] SGN_SU = 2'b10;
   localparam logic [1:0] SGN_SS = 2'b11;

endpackage

// File: rtl/muldiv_special_detect.sv
// Recognises divide-by-zero and signed-overflow divides and produces their
// architectural result so the divider is never occupied for them.
module muldiv_special_detect #(
   parameter int unsigned XLEN = 64
) (
   input  logic [2:0]      op,
   input  logic            word,
   input  logic [XLEN-1:0] src1,
   input  logic [XLEN-1:0] src2,
   output logic            hit,
   output logic [XLEN-1:0] result
);
   import muldiv_sched_pkg::*;

   localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

   logic [XLEN-1:0] dividend;
   logic            dvs_zero;
   logic            ovf;

   always_comb begin
      dividend = word ? {{(XLEN-32){src1[31]}}, src1[31:0]} : src1;
      dvs_zero = word ? (src2[31:0] == 32'h0) : (src2 == '0);
      ovf      = word ? (src1[31:0] == 32'h8000_0000 && src2[31:0] == 32'hFFFF_FFFF)
                      : (src1 == MIN_NEG && src2 == '1);
      hit      = 1'b0;
      result   = '0;
      if (op[2]) begin
         if (dvs_zero) begin
            hit    = 1'b1;
            result = op[1] ? dividend : '1;
         end else if (ovf && (op == OP_DIV || op == OP_REM)) begin
            hit    = 1'b1;
            result = op[1] ? '0 : dividend;
         end
      end
   end

endmodule

// File: rtl/muldiv_sched.sv
// Issue/sequencing controller sharing one iterative multiplier and one
// iterative divider; results are held on a valid/ready response port.
module muldiv_sched #(
   parameter int unsigned XLEN = 64
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            flush,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic [2:0]      req_op,
   input  logic            req_word,
   input  logic [XLEN-1:0] req_src1,
   input  logic [XLEN-1:0] req_src2,
   output logic            resp_valid,
   input  logic            resp_ready,
   output logic [XLEN-1:0] resp_data,
   output logic            mul_valid,
   input  logic            mul_ready,
   output logic            mul_flush,
   output logic            mul_w,
   output logic [1:0]      mul_signed,
   output logic [XLEN-1:0] mul_src1,
   output logic [XLEN-1:0] mul_src2,
   input  logic            mul_out_valid,
   input  logic [XLEN-1:0] mul_res_h,
   input  logic [XLEN-1:0] mul_res_l,
   output logic            div_valid,
   input  logic            div_ready,
   output logic            div_flush,
   output logic            div_w,
   output logic [1:0]      div_signed,
   output logic [XLEN-1:0] div_src1,
   output logic [XLEN-1:0] div_src2,
   input  logic            div_out_valid,
   input  logic [XLEN-1:0] div_quot,
   input  logic [XLEN-1:0] div_rem
);
   import muldiv_sched_pkg::*;

   state_t          state, state_nx;
   op_t             op_q;
   logic            word_q;
   logic            armed;
   logic [XLEN-1:0] src1_q, src2_q, res_q;
   logic [XLEN-1:0] raw_res, sel_res;
   logic            sp_hit;
   logic [XLEN-1:0] sp_res;
   logic            is_div, accept, unit_hs, unit_done;

   assign is_div    = op_q[2];
   assign accept    = req_valid & req_ready;
   assign unit_hs   = is_div ? (div_valid & div_ready) : (mul_valid & mul_ready);
   assign unit_done = is_div ? div_out_valid : mul_out_valid;

   muldiv_special_detect #(.XLEN(XLEN)) u_special (
      .op     (req_op),
      .word   (req_word),
      .src1   (req_src1),
      .src2   (req_src2),
      .hit    (sp_hit),
      .result (sp_res)
   );

   // armed keeps req_ready low until the first edge after reset release
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state <= ST_IDLE;
         armed <= 1'b0;
      end else begin
         state <= state_nx;
         armed <= 1'b1;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE:  if (accept) state_nx = sp_hit ? ST_DONE : ST_ISSUE;
         ST_ISSUE: if (unit_hs) state_nx = ST_BUSY;
         ST_BUSY:  if (unit_done) state_nx = ST_DONE;
         ST_DONE:  if (resp_ready) state_nx = ST_IDLE;
         default:  state_nx = ST_IDLE;
      endcase
      if (flush) state_nx = ST_IDLE;
   end

   always_comb begin
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      mul_valid  = 1'b0;
      div_valid  = 1'b0;
      mul_flush  = 1'b0;
      div_flush  = 1'b0;
      case (state)
         ST_IDLE:  req_ready = armed & ~flush;
         ST_ISSUE: begin
            mul_valid = ~is_div;
            div_valid = is_div;
            mul_flush = flush & ~is_div;
            div_flush = flush & is_div;
         end
         ST_BUSY: begin
            mul_flush = flush & ~is_div;
            div_flush = flush & is_div;
         end
         ST_DONE:  resp_valid = 1'b1;
         default:  ;
      endcase
   end

   always_comb begin
      if (is_div) raw_res = op_q[1] ? div_rem : div_quot;
      else        raw_res = (op_q == OP_MUL) ? mul_res_l : mul_res_h;
      sel_res = word_q ? {{(XLEN-32){raw_res[31]}}, raw_res[31:0]} : raw_res;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         op_q   <= OP_MUL;
         word_q <= 1'b0;
         src1_q <= '0;
         src2_q <= '0;
         res_q  <= '0;
      end else begin
         if (accept) begin
            op_q   <= op_t'(req_op);
            word_q <= req_word;
            src1_q <= req_src1;
            src2_q <= req_src2;
            if (sp_hit) res_q <= sp_res;
         end
         if (state == ST_BUSY && unit_done && !flush) res_q <= sel_res;
      end
   end

   always_comb begin
      case (op_q)
         OP_MULH:   mul_signed = SGN_SS;
         OP_MULHSU: mul_signed = SGN_SU;
         default:   mul_signed = SGN_UU;
      endcase
      div_signed = (op_q == OP_DIV || op_q == OP_REM) ? SGN_SS : SGN_UU;
   end

   assign mul_w     = word_q;
   assign div_w     = word_q;
   assign mul_src1  = src1_q;
   assign mul_src2  = src2_q;
   assign div_src1  = src1_q;
   assign div_src2  = src2_q;
   assign resp_data = res_q;

endmodule

// File: tb/tb_muldiv_sched.sv
// Randomised and directed bench for muldiv_sched with a transaction-level
// RV64M reference and simple multiplier/divider environment models.
module tb_muldiv_sched;
   localparam int unsigned XLEN = 64;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic            reset, flush, req_valid, req_ready, req_word;
   logic [2:0]      req_op;
   logic [63:0]     req_src1, req_src2, resp_data;
   logic            resp_valid, resp_ready;
   logic            mul_valid, mul_ready, mul_flush, mul_w, mul_out_valid;
   logic [1:0]      mul_signed, div_signed;
   logic [63:0]     mul_src1, mul_src2, mul_res_h, mul_res_l;
   logic            div_valid, div_ready, div_flush, div_w, div_out_valid;
   logic [63:0]     div_src1, div_src2, div_quot, div_rem;

   muldiv_sched #(.XLEN(XLEN)) dut (
      .clock(clock), .reset(reset), .flush(flush),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_word(req_word),
      .req_src1(req_src1), .req_src2(req_src2),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
      .mul_valid(mul_valid), .mul_ready(mul_ready), .mul_flush(mul_flush), .mul_w(mul_w),
      .mul_signed(mul_signed), .mul_src1(mul_src1), .mul_src2(mul_src2),
      .mul_out_valid(mul_out_valid), .mul_res_h(mul_res_h), .mul_res_l(mul_res_l),
      .div_valid(div_valid), .div_ready(div_ready), .div_flush(div_flush), .div_w(div_w),
      .div_signed(div_signed), .div_src1(div_src1), .div_src2(div_src2),
      .div_out_valid(div_out_valid), .div_quot(div_quot), .div_rem(div_rem)
   );

   int unsigned total = 0;
   int unsigned bad   = 0;

   typedef enum {P_IDLE, P_ISSUE, P_WAIT, P_RESP} ph_t;
   ph_t         ph = P_IDLE;
   bit          armed = 0;
   logic [2:0]  t_op = '0;
   logic        t_w = 1'b0;
   logic [63:0] t_a = '0, t_b = '0, t_exp = '0;

   logic        s_valid = 0, s_word = 0, s_flush = 0, s_rready = 1, s_rst = 0;
   logic [2:0]  s_op = '0;
   logic [63:0] s_a = '0, s_b = '0;
   bit          auto_mode = 0, stray_en = 0, rand_ready = 0, force_div_stray = 0;
   int unsigned mul_lat = 4, div_lat = 4, div_hold = 0, resp_hold = 0;
   bit          mu_busy = 0, du_busy = 0;
   int unsigned mu_cnt = 0, du_cnt = 0;
   logic [63:0] mu_h = '0, mu_l = '0, du_q = '0, du_r = '0;
   bit          acc_seen = 0, resp_seen = 0;
   logic [63:0] last_resp = '0;
   logic [1:0]  last_msgn = '0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [63:0] sx32(input logic [31:0] v);
      return {{32{v[31]}}, v};
   endfunction

   // Divider behaviour for ordinary operands; special inputs give a poison value.
   function automatic void unit_div(input bit s, input bit w, input logic [63:0] a,
                                    input logic [63:0] b, output logic [63:0] q,
                                    output logic [63:0] r);
      longint      sa, sb;
      logic [63:0] ua, ub, tq, tr;
      q = 64'hDEAD_BEEF_DEAD_BEEF;
      r = 64'hDEAD_BEEF_DEAD_BEEF;
      if (w) begin
         if (b[31:0] == 32'h0) return;
         if (s) begin
            sa = {{32{a[31]}}, a[31:0]};
            sb = {{32{b[31]}}, b[31:0]};
            if (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF) return;
            tq = sa / sb;
            tr = sa % sb;
         end else begin
            ua = {32'h0, a[31:0]};
            ub = {32'h0, b[31:0]};
            tq = ua / ub;
            tr = ua % ub;
         end
         q = sx32(tq[31:0]);
         r = sx32(tr[31:0]);
      end else begin
         if (b == 64'h0) return;
         if (s) begin
            if (a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF) return;
            sa = a;
            sb = b;
            q = sa / sb;
            r = sa % sb;
         end else begin
            q = a / b;
            r = a % b;
         end
      end
   endfunction

   function automatic logic [127:0] umul(input logic [1:0] sg, input logic [63:0] a,
                                         input logic [63:0] b);
      logic [127:0] x, y;
      x = sg[1] ? {{64{a[63]}}, a} : {64'h0, a};
      y = sg[0] ? {{64{b[63]}}, b} : {64'h0, b};
      return x * y;
   endfunction

   function automatic bit is_special(input logic [2:0] op, input logic w,
                                     input logic [63:0] a, input logic [63:0] b);
      bit zero, ovf;
      zero = w ? (b[31:0] == 32'h0) : (b == 64'h0);
      ovf  = w ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
               : (a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF);
      return op[2] && (zero || (!op[0] && ovf));
   endfunction

   // Architectural RV64M result.
   function automatic logic [63:0] ref_m(input logic [2:0] op, input logic w,
                                         input logic [63:0] a, input logic [63:0] b);
      logic [127:0] p;
      logic [63:0]  res, q, r, ea;
      bit           sgn;
      if (!op[2]) begin
         case (op)
            3'b001:  p = umul(2'b11, a, b);
            3'b010:  p = umul(2'b10, a, b);
            default: p = umul(2'b00, a, b);
         endcase
         res = (op == 3'b000) ? p[63:0] : p[127:64];
         return w ? sx32(res[31:0]) : res;
      end
      sgn = !op[0];
      ea  = w ? sx32(a[31:0]) : a;
      if (w ? (b[31:0] == 32'h0) : (b == 64'h0)) return op[1] ? ea : 64'hFFFF_FFFF_FFFF_FFFF;
      if (sgn && is_special(op, w, a, b)) return op[1] ? 64'h0 : ea;
      unit_div(sgn, w, a, b, q, r);
      return op[1] ? r : q;
   endfunction

   function automatic logic [63:0] rand_opnd();
      case ($urandom_range(0, 7))
         0:       return 64'h0;
         1:       return 64'hFFFF_FFFF_FFFF_FFFF;
         2:       return 64'h8000_0000_0000_0000;
         3:       return 64'h0000_0000_8000_0000;
         4:       return 64'h0000_0000_FFFF_FFFF;
         5:       return 64'($urandom_range(0, 20));
         default: return {$urandom, $urandom};
      endcase
   endfunction

   function automatic logic [1:0] exp_msgn(input logic [2:0] op);
      case (op)
         3'b001:  return 2'b11;
         3'b010:  return 2'b10;
         default: return 2'b00;
      endcase
   endfunction

   task automatic check_outputs();
      bit mv, dv, busy;
      mv   = (ph == P_ISSUE) && !t_op[2];
      dv   = (ph == P_ISSUE) && t_op[2];
      busy = (ph == P_ISSUE) || (ph == P_WAIT);
      chk("req_ready", req_ready, armed && ph == P_IDLE && !flush);
      chk("resp_valid", resp_valid, ph == P_RESP);
      if (ph == P_RESP) chk("resp_data", resp_data, t_exp);
      chk("mul_valid", mul_valid, mv);
      chk("div_valid", div_valid, dv);
      chk("mul_flush", mul_flush, flush && busy && !t_op[2]);
      chk("div_flush", div_flush, flush && busy && t_op[2]);
      if (mv) begin
         chk("mul_signed", mul_signed, exp_msgn(t_op));
         chk("mul_w", mul_w, t_w);
         chk("mul_src1", mul_src1, t_a);
         chk("mul_src2", mul_src2, t_b);
      end
      if (dv) begin
         chk("div_signed", div_signed, (t_op == 3'b100 || t_op == 3'b110) ? 2'b11 : 2'b00);
         chk("div_w", div_w, t_w);
         chk("div_src1", div_src1, t_a);
         chk("div_src2", div_src2, t_b);
      end
   endtask

   task automatic model_step();
      bit acc;
      if (mul_flush) mu_busy = 0;
      if (div_flush) du_busy = 0;
      if (mul_valid && mul_ready && !mul_flush) begin
         mu_busy = 1;
         mu_cnt  = mul_lat - 1;
         {mu_h, mu_l} = umul(mul_signed, mul_src1, mul_src2);
         last_msgn = mul_signed;
      end
      if (div_valid && div_ready && !div_flush) begin
         du_busy = 1;
         du_cnt  = div_lat - 1;
         unit_div(div_signed[1], div_w, div_src1, div_src2, du_q, du_r);
      end
      if (!reset) begin
         ph = P_IDLE;
         armed = 0;
         mu_busy = 0;
         du_busy = 0;
         return;
      end
      if (ph == P_RESP && resp_ready) begin
         resp_seen = 1;
         last_resp = resp_data;
      end
      acc = armed && ph == P_IDLE && req_valid && !flush;
      if (flush) ph = P_IDLE;
      else begin
         case (ph)
            P_IDLE: if (acc) begin
               t_op = req_op; t_w = req_word; t_a = req_src1; t_b = req_src2;
               t_exp = ref_m(req_op, req_word, req_src1, req_src2);
               ph = is_special(req_op, req_word, req_src1, req_src2) ? P_RESP : P_ISSUE;
               acc_seen = 1;
            end
            P_ISSUE: if (t_op[2] ? div_ready : mul_ready) ph = P_WAIT;
            P_WAIT:  if (t_op[2] ? div_out_valid : mul_out_valid) ph = P_RESP;
            P_RESP:  if (resp_ready) ph = P_IDLE;
            default: ph = P_IDLE;
         endcase
      end
      armed = 1;
   endtask

   task automatic cycle();
      @(negedge clock);
      if (auto_mode) begin
         s_valid  = $urandom_range(0, 9) < 7;
         s_op     = 3'($urandom_range(0, 7));
         s_word   = (s_op == 3'b000 || s_op[2]) && ($urandom_range(0, 2) == 0);
         s_a      = rand_opnd();
         s_b      = rand_opnd();
         s_flush  = $urandom_range(0, 29) == 0;
         s_rready = $urandom_range(0, 9) < 6;
         mul_lat  = $urandom_range(1, 6);
         div_lat  = $urandom_range(1, 6);
      end
      reset = s_rst; flush = s_flush; req_valid = s_valid; req_op = s_op;
      req_word = s_word; req_src1 = s_a; req_src2 = s_b;
      if (resp_hold > 0) begin
         resp_ready = 1'b0;
         if (ph == P_RESP) resp_hold--;
      end else resp_ready = s_rready;
      mul_out_valid = 1'b0;
      div_out_valid = 1'b0;
      if (mu_busy) begin
         if (mu_cnt == 0) begin
            mul_out_valid = 1'b1; mul_res_h = mu_h; mul_res_l = mu_l; mu_busy = 0;
         end else mu_cnt--;
      end else if (stray_en && !(ph == P_WAIT && !t_op[2]) && $urandom_range(0, 9) == 0) begin
         mul_out_valid = 1'b1; mul_res_h = {$urandom, $urandom}; mul_res_l = {$urandom, $urandom};
      end
      if (du_busy) begin
         if (du_cnt == 0) begin
            div_out_valid = 1'b1; div_quot = du_q; div_rem = du_r; du_busy = 0;
         end else du_cnt--;
      end else if (force_div_stray ||
                   (stray_en && !(ph == P_WAIT && t_op[2]) && $urandom_range(0, 9) == 0)) begin
         div_out_valid = 1'b1; div_quot = {$urandom, $urandom}; div_rem = {$urandom, $urandom};
         force_div_stray = 0;
      end
      mul_ready = !mu_busy && (!rand_ready || $urandom_range(0, 3) != 0);
      if (div_hold > 0) begin
         div_ready = 1'b0;
         div_hold--;
      end else div_ready = !du_busy && (!rand_ready || $urandom_range(0, 3) != 0);
      #1;
      check_outputs();
      model_step();
   endtask

   task automatic run_txn(input string name, input logic [2:0] op, input logic w,
                          input logic [63:0] a, input logic [63:0] b, input logic [63:0] want);
      int unsigned n = 0;
      s_op = op; s_word = w; s_a = a; s_b = b; s_valid = 1; s_rready = 1;
      acc_seen = 0; resp_seen = 0;
      while (!acc_seen && n < 50) begin cycle(); n++; end
      s_valid = 0;
      while (!resp_seen && n < 200) begin cycle(); n++; end
      if (!resp_seen) chk({name, "_timeout"}, 64'd0, 64'd1);
      else chk(name, last_resp, want);
   endtask

   task automatic chk_all_zero(input string name);
      chk({name, "_req_ready"}, req_ready, 0);
      chk({name, "_resp_valid"}, resp_valid, 0);
      chk({name, "_resp_data"}, resp_data, 0);
      chk({name, "_valids"}, {mul_valid, div_valid, mul_flush, div_flush}, 0);
      chk({name, "_ctl"}, {mul_w, div_w, mul_signed, div_signed}, 0);
      chk({name, "_srcs"}, mul_src1 | mul_src2 | div_src1 | div_src2, 0);
   endtask

   task automatic wait_phase(input ph_t p, input string name);
      int unsigned n = 0;
      while (ph != p && n < 50) begin cycle(); n++; end
      if (ph != p) chk({name, "_phase_timeout"}, 64'd0, 64'd1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 0; flush = 0; req_valid = 0; req_op = '0; req_word = 0;
      req_src1 = '0; req_src2 = '0; resp_ready = 0;
      mul_ready = 0; mul_out_valid = 0; mul_res_h = '0; mul_res_l = '0;
      div_ready = 0; div_out_valid = 0; div_quot = '0; div_rem = '0;

      chk("pin_mul", ref_m(3'b000, 0, 64'd7, -64'sd3), 64'hFFFF_FFFF_FFFF_FFEB);
      chk("pin_mulhu", ref_m(3'b011, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2), 64'h1);
      chk("pin_divw_ovf", ref_m(3'b100, 1, 64'h8000_0000, 64'hFFFF_FFFF), 64'hFFFF_FFFF_8000_0000);
      chk("pin_div", ref_m(3'b100, 0, 64'd100, 64'd7), 64'd14);

      cycle(); cycle();
      chk_all_zero("reset");
      s_rst = 1;
      cycle();
      chk("ready_after_release", req_ready, 0);
      cycle();
      chk("ready_armed", req_ready, 1);

      mul_lat = 4;
      run_txn("mul_7x-3", 3'b000, 0, 64'd7, -64'sd3, 64'hFFFF_FFFF_FFFF_FFEB);
      chk("mul_sgn", last_msgn, 2'b00);
      run_txn("mulhu", 3'b011, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'h1);
      run_txn("mulh", 3'b001, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0);
      chk("mulh_sgn", last_msgn, 2'b11);
      run_txn("div_by0", 3'b100, 0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF);
      run_txn("remu_by0", 3'b111, 0, 64'd5, 64'd0, 64'd5);
      run_txn("divw_ovf", 3'b100, 1, 64'h8000_0000, 64'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0000);
      run_txn("remw_ovf", 3'b110, 1, 64'h8000_0000, 64'hFFFF_FFFF, 64'h0);
      div_hold = 4; resp_hold = 5;
      run_txn("div_100_7", 3'b100, 0, 64'd100, 64'd7, 64'd14);

      // flush while the divider is working
      div_lat = 12;
      s_op = 3'b100; s_word = 0; s_a = 64'd100; s_b = 64'd7; s_valid = 1; acc_seen = 0;
      wait_phase(P_WAIT, "flush_busy");
      s_valid = 0; s_flush = 1;
      cycle();
      chk("flush_pulse", div_flush, 1);
      s_flush = 0;
      cycle();
      chk("flush_pulse_end", div_flush, 0);
      chk("idle_after_flush", req_ready, 1);
      force_div_stray = 1;
      for (int i = 0; i < 4; i++) begin
         cycle();
         chk("stray_ignored", resp_valid, 0);
      end

      // reset in the middle of a multiply
      mul_lat = 12;
      s_op = 3'b000; s_a = 64'd7; s_b = -64'sd3; s_valid = 1; acc_seen = 0;
      wait_phase(P_WAIT, "reset_busy");
      s_valid = 0;
      #1 reset = 0;
      #1 chk_all_zero("async_reset");
      ph = P_IDLE; armed = 0; mu_busy = 0; du_busy = 0;
      s_rst = 0;
      cycle(); cycle();
      s_rst = 1;
      cycle();
      chk("ready_after_rst2", req_ready, 0);

      auto_mode = 1; stray_en = 1; rand_ready = 1;
      for (int i = 0; i < 3000; i++) cycle();
      auto_mode = 0; stray_en = 0; rand_ready = 0;
      s_valid = 0; s_flush = 0; s_rready = 1;
      for (int i = 0; i < 20; i++) cycle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/muldiv_sched.md
Name: muldiv_sched

Overview:
Issue and sequencing controller that shares one iterative multiplier and one iterative divider between the execute stage and the load/store stage. It accepts RV64M operations through a valid/ready request port, dispatches them to the correct unit with the correct signedness and word-mode controls, and resolves the RISC-V divide special cases without occupying the divider. It holds each result on a valid/ready response port until the load/store stage accepts it, and supports pipeline flush.

Parameters:
XLEN, 64, datapath width; all operand and result buses.

Ports:
clock  in  1  single clock
reset  in  1  asynchronous, active-low reset
flush  in  1  abort the in-flight operation
req_valid  in  1  execute stage presents an operation
req_ready  out  1  scheduler can accept
req_op  in  3  M-extension funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
req_word  in  1  *W variant
req_src1  in  XLEN  rs1 operand
req_src2  in  XLEN  rs2 operand
resp_valid  out  1  result available
resp_ready  in  1  load/store stage accepts
resp_data  out  XLEN  result
mul_valid  out  1  issue to multiplier
mul_ready  in  1  multiplier can accept
mul_flush  out  1  abort multiplier
mul_w  out  1  word mode
mul_signed  out  2  {src1 signed, src2 signed}
mul_src1  out  XLEN  multiplicand
mul_src2  out  XLEN  multiplier
mul_out_valid  in  1  multiplier result valid (1-cycle pulse)
mul_res_h  in  XLEN  product high half
mul_res_l  in  XLEN  product low half
div_valid  out  1  issue to divider
div_ready  in  1  divider can accept
div_flush  out  1  abort divider
div_w  out  1  word mode
div_signed  out  2  signedness
div_src1  out  XLEN  dividend
div_src2  out  XLEN  divisor
div_out_valid  in  1  divider result valid (1-cycle pulse)
div_quot  in  XLEN  quotient
div_rem  in  XLEN  remainder

Behaviour:
- Reset, asynchronous and active-low: state goes to IDLE. All outputs and latched registers are 0. req_ready becomes 1 only after reset is released.
- States:
  - IDLE: req_ready is !flush. When req_valid & req_ready, latch op, word and both operands, then branch:
    - special case -> DONE
    - otherwise -> ISSUE
  - ISSUE: mul_valid = (op[2]==0) and div_valid = (op[2]==1), driven from the latched registers. When the selected unit's valid & ready both hold -> BUSY.
  - BUSY: on the selected unit's out_valid, capture the result -> DONE. An out_valid from the other unit is ignored.
  - DONE: resp_valid=1 and resp_data is held stable. When resp_ready -> IDLE. No new request is accepted in the same cycle.
- Unit controls:
  - mul_signed: MULH=11, MULHSU=10, MULHU=00, MUL=00.
  - div_signed: 11 for DIV/REM, 00 for DIVU/REMU.
  - mul_w and div_w equal the latched word bit.
- Result selection:
  - MUL -> res_l; MULH, MULHSU and MULHU -> res_h.
  - DIV/DIVU -> quot; REM/REMU -> rem.
  - If word, resp_data = sign-extension of the selected result's bits [31:0].
- Special cases, checked at accept time on the effective operands (bits [31:0] when word):
  - Divisor 0:
    - DIV/DIVU give all ones.
    - REM/REMU give the dividend.
    - Word results are sign-extended from 32 bits.
  - Signed overflow (DIV/REM only; dividend = most negative value, divisor = -1):
    - DIV gives the dividend.
    - REM gives 0.
- Latency:
  - Special case: resp_valid one cycle after accept.
  - Normal path: unit issue one cycle after accept, then resp_valid one cycle after out_valid.
- Flush, in any state: next state is IDLE and resp_valid drops next cycle.
  - If the state is ISSUE or BUSY, assert the selected unit's *_flush for exactly one cycle.
  - Flush in IDLE together with req_valid means the request is not accepted.
  - Flush in DONE together with resp_ready means the state goes to IDLE with no flush pulse.
- A unit out_valid arriving in the cycle after a flush is discarded.

Decomposition:
- Shared package:
  - XLEN
  - state encoding (IDLE, ISSUE, BUSY, DONE)
  - the eight op encodings
  - signedness constants
- One combinational sub-module, muldiv_special_detect: inputs op, word, src1, src2; outputs hit and result.

Test Plan:
- MUL 7*(-3), XLEN=64, unit latency 4 -> mul_signed=00, resp_data=0xFFFFFFFFFFFFFFEB, resp_valid one cycle after mul_out_valid.
- MULHU 0xFFFFFFFFFFFFFFFF*2 -> resp_data=0x1; MULH (-1)*(-1) -> mul_signed=11, resp_data=0.
- DIV by 0 with src1=5 -> no div_valid, resp_data=0xFFFFFFFFFFFFFFFF one cycle after accept; REMU by 0 -> resp_data=5.
- DIVW 0x80000000 / 0xFFFFFFFF -> resp_data=0xFFFFFFFF80000000, no div_valid; REMW on the same operands -> 0.
- DIV 100/7 with div_ready held low 3 cycles -> div_valid stays asserted in ISSUE, then resp_data=14; resp_ready held low 5 cycles -> resp_data stable and req_ready=0 throughout.
- Flush in BUSY -> div_flush high for one cycle, IDLE next, later stray div_out_valid produces no resp_valid; reset asserted mid-BUSY -> all outputs 0 immediately.
